// File: rtl/majority_vote_sequencer.sv
// majority_vote_sequencer
//   Sequential ballot controller. A start pulse opens a voting session. Each
//   voter then casts one ballot as a {vote_id, vote_bit} strobe. Duplicate
//   ballots and ballots with an out-of-range id are rejected and reported on
//   vote_err. Once every voter has voted, the block spends one cycle in DECIDE.
//   It then pulses done and drives led with the majority verdict, which means
//   strictly more than N_VOTERS/2 yes votes.
//
//   Optional feature, enabled with the macro VOTE_TIMEOUT_EN:
//     A COLLECT-state cycle counter forces a decision after TIMEOUT_CYC cycles.
//     Voters who have not voted count as "no", and the sticky timeout flag is
//     set. When the macro is undefined, no counter is built and timeout is 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle pulse, opens a session from IDLE
//   vote_valid in   ballot strobe, one ballot per asserted cycle
//   vote_id    in   voter index 0..N_VOTERS-1 (ID_W bits)
//   vote_bit   in   1 = yes, 0 = no
//   busy       out  high in COLLECT and DECIDE
//   done       out  one-cycle pulse when led carries a fresh verdict
//   led        out  majority verdict, held until the next start
//   yes_count  out  yes votes accepted this session (CNT_W bits)
//   voted_mask out  bit i set once voter i has voted
//   vote_err   out  one-cycle pulse after a rejected ballot
//   timeout    out  sticky; session ended by timeout, cleared on start
module majority_vote_sequencer #(
    parameter int N_VOTERS    = 5,
    parameter int ID_W        = 3,
    parameter int CNT_W       = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                vote_valid,
    input  logic [ID_W-1:0]     vote_id,
    input  logic                vote_bit,
    output logic                busy,
    output logic                done,
    output logic                led,
    output logic [CNT_W-1:0]    yes_count,
    output logic [N_VOTERS-1:0] voted_mask,
    output logic                vote_err,
    output logic                timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DECIDE  = 2'd2
    } state_t;

    // The majority test compares 2*yes_count with N_VOTERS using one extra
    // bit, so the doubled count cannot overflow.
    localparam logic [CNT_W:0] N_CMP = (CNT_W+1)'(N_VOTERS);

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]    yes_q, yes_d;
    logic                led_q, led_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // id_hit is a one-hot decode of vote_id. An out-of-range id decodes to
    // all zeros, so it is rejected without any separate range compare.
    logic [N_VOTERS-1:0] id_hit;
    logic [N_VOTERS-1:0] new_voter;
    logic                accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_VOTERS; gi++) begin : g_decode
            assign id_hit[gi] = (vote_id == ID_W'(gi));
        end
    endgenerate

    assign new_voter = id_hit & ~mask_q;
    assign accept    = vote_valid && (|new_voter);

`ifdef VOTE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        yes_d   = yes_q;
        led_d   = led_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef VOTE_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    mask_d  = '0;
                    yes_d   = '0;
                    led_d   = 1'b0;
`ifdef VOTE_TIMEOUT_EN
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
`endif
                end
            end
            S_COLLECT: begin
                if (vote_valid) begin
                    if (accept) begin
                        mask_d = mask_q | new_voter;
                        yes_d  = yes_q + {{(CNT_W-1){1'b0}}, vote_bit};
                        if (&(mask_q | new_voter)) begin
                            state_d = S_DECIDE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
`ifdef VOTE_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                // A final ballot on the same edge wins. The session then
                // decides normally and timeout stays clear.
                if (state_d == S_COLLECT && cnt_q == TO_W'(TIMEOUT_CYC-1)) begin
                    state_d = S_DECIDE;
                    tmo_d   = 1'b1;
                end
`endif
            end
            S_DECIDE: begin
                led_d   = ({1'b0, yes_q} << 1) > N_CMP;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            yes_q   <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            yes_q   <= yes_d;
            led_q   <= led_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef VOTE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign led        = led_q;
    assign yes_count  = yes_q;
    assign voted_mask = mask_q;
    assign vote_err   = err_q;
`ifdef VOTE_TIMEOUT_EN
    assign timeout    = tmo_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_majority_vote_sequencer.sv
module tb_majority_vote_sequencer;
    localparam int N   = 5;
    localparam int IDW = 3;
    localparam int CW  = 3;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          vote_valid = 1'b0;
    logic [IDW-1:0] vote_id = '0;
    logic          vote_bit = 1'b0;
    logic          busy, done, led, vote_err, timeout;
    logic [CW-1:0] yes_count;
    logic [N-1:0]  voted_mask;

    majority_vote_sequencer #(
        .N_VOTERS(N), .ID_W(IDW), .CNT_W(CW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid),
        .vote_id(vote_id), .vote_bit(vote_bit), .busy(busy), .done(done),
        .led(led), .yes_count(yes_count), .voted_mask(voted_mask),
        .vote_err(vote_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       led;
        int         yes;
        logic [N-1:0] mask;
        logic       tmo;
    } verdict_t;

    typedef struct {
        int         cyc;
        int         yes;
        logic [N-1:0] mask;
    } reject_t;

    verdict_t vq[$];
    reject_t  rq[$];

    // Reference model: one ballot box per session.
    bit in_sess    = 1'b0;
    int sess_start = 0;
    int idle_after = -10;
    bit voted[N];
    int yes_m = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [N-1:0] mask_of();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = voted[i];
        return m;
    endfunction

    function automatic bit all_voted();
        for (int i = 0; i < N; i++) if (!voted[i]) return 1'b0;
        return 1'b1;
    endfunction

    // A decision taken on edge e shows up as done on edge e+1.
    function automatic void decide(input int e, input bit tmo);
        verdict_t v;
        v.cyc  = e + 1;
        v.led  = (2 * yes_m > N);
        v.yes  = yes_m;
        v.mask = mask_of();
        v.tmo  = tmo;
        vq.push_back(v);
        in_sess    = 1'b0;
        idle_after = e + 1;
    endfunction

    task automatic step(input bit v, input int id, input bit b, input bit st);
        int e;
        reject_t r;
        @(negedge clk);
        vote_valid = v;
        vote_id    = id[IDW-1:0];
        vote_bit   = b;
        start      = st;
        @(posedge clk);
        #1;
        e = cyc;
        if (in_sess) begin
            if (v) begin
                if (id < N && !voted[id]) begin
                    voted[id] = 1'b1;
                    yes_m += b;
                    if (all_voted()) decide(e, 1'b0);
                end else begin
                    r.cyc  = e;
                    r.yes  = yes_m;
                    r.mask = mask_of();
                    rq.push_back(r);
                end
            end
`ifdef VOTE_TIMEOUT_EN
            if (in_sess && (e - sess_start) == TO) decide(e, 1'b1);
`endif
        end else if (st && e > idle_after) begin
            in_sess    = 1'b1;
            sess_start = e;
            yes_m      = 0;
            for (int i = 0; i < N; i++) voted[i] = 1'b0;
        end
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        step(1'b0, 0, 1'b0, 1'b1);
        chk("busy_after_start", busy, 1);
        chk("timeout_cleared_on_start", timeout, 0);
    endtask

    task automatic vote(input int id, input bit b);
        step(1'b1, id, b, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_led"}, led, 0);
        chk({tag, "_yes_count"}, yes_count, 0);
        chk({tag, "_voted_mask"}, voted_mask, 0);
        chk({tag, "_vote_err"}, vote_err, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic wait_verdicts();
        int n = 0;
        while (vq.size() != 0 && n < 100) begin
            idle();
            n++;
        end
        chk("verdict_arrived_in_time", vq.size(), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents done or vote_err.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (vq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    verdict_t v;
                    v = vq.pop_front();
                    $display("verdict cyc=%0d led=%0b yes=%0d mask=%b tmo=%0b", cyc, led, yes_count, voted_mask, timeout);
                    chk("done_cycle", cyc, v.cyc);
                    chk("led", led, v.led);
                    chk("yes_count", yes_count, v.yes);
                    chk("voted_mask", voted_mask, v.mask);
                    chk("timeout", timeout, v.tmo);
                    chk("busy_at_done", busy, 0);
                end
            end
            if (vote_err) begin
                if (rq.size() == 0) begin
                    chk("unexpected_vote_err", 1, 0);
                end else begin
                    reject_t r;
                    r = rq.pop_front();
                    $display("reject  cyc=%0d yes=%0d mask=%b", cyc, yes_count, voted_mask);
                    chk("err_cycle", cyc, r.cyc);
                    chk("err_yes_count", yes_count, r.yes);
                    chk("err_voted_mask", voted_mask, r.mask);
                end
            end
        end
    end

    initial begin
        int nv;
        // Reset.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Ballot with 3 yes votes; the next session starts on the done cycle.
        do_start();
        vote(0, 1); vote(1, 1); vote(2, 0); vote(3, 1); vote(4, 0);
        idle();
        do_start();
        vote(0, 0); vote(1, 1); vote(2, 0); vote(3, 1); vote(4, 0);
        idle();

        // Duplicate and out-of-range ballots.
        do_start();
        vote(2, 1); vote(2, 0); vote(5, 1); vote(7, 0);
        vote(0, 0); vote(1, 0); vote(3, 0); vote(4, 1);
        idle();
        idle();

        // Ballots while idle are ignored.
        vote(3, 1); vote(6, 1);
        idle();

        // Reset mid-session.
        do_start();
        vote(0, 1); vote(1, 1); vote(2, 1);
        @(negedge clk);
        vote_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        in_sess    = 1'b0;
        idle_after = -10;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        vote(0, 1); vote(1, 0); vote(2, 1); vote(3, 1); vote(4, 1);
        idle();

        // Randomised sessions.
        for (int s = 0; s < 20; s++) begin
            do_start();
            nv = $urandom_range(2, 10);
            for (int k = 0; k < nv && in_sess; k++) begin
                step(($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 1));
            end
            for (int i = 0; i < N; i++) begin
                if (in_sess && !voted[i]) vote(i, $urandom_range(0, 1));
            end
            idle();
        end
        wait_verdicts();

`ifdef VOTE_TIMEOUT_EN
        // Timeout with 3 yes votes, then with 2.
        idle();
        do_start();
        vote(0, 1); vote(1, 1); vote(2, 1);
        wait_verdicts();
        idle();
        chk("timeout_sticky", timeout, 1);
        do_start();
        vote(0, 1); vote(1, 1);
        wait_verdicts();
        idle();
`endif

        repeat (3) idle();
        chk("verdict_queue_empty", vq.size(), 0);
        chk("reject_queue_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
